// File: rtl/map_dec_pkg.sv
// map_dec_pkg: shared constants and helpers for the max-log-MAP metric datapath.
// Holds the max* correction table and the saturating add used by the
// MAX_TREE_CORR_EN build of max2_cell.
package map_dec_pkg;

  // Correction table: d == T0 -> V0, d <= T1 -> V1, d <= T2 -> V2, else 0.
  localparam int CORR_T0 = 0;
  localparam int CORR_T1 = 2;
  localparam int CORR_T2 = 5;
  localparam int CORR_V0 = 3;
  localparam int CORR_V1 = 2;
  localparam int CORR_V2 = 1;

  // Index width for an m-input tree; at least one bit.
  function automatic int iw_of(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // x + c, clipped at the largest n-bit value (signed or unsigned).
  // x arrives already extended to 34 bits in the caller's signedness.
  function automatic logic signed [33:0] sat_add(input logic signed [33:0] x,
                                                 input logic [1:0]         c,
                                                 input int                 n,
                                                 input bit                 sgn);
    logic signed [33:0] lim;
    logic signed [33:0] sum;
    lim = (34'sd1 <<< (sgn ? (n - 1) : n)) - 34'sd1;
    sum = x + $signed({32'd0, c});
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/max2_cell.sv
// max2_cell: combinational pairwise max/argmax. Input a is the lower-index
// operand and wins ties. With MAX_TREE_CORR_EN defined, the result becomes
// max* = max + corr(|a-b|), saturated; the index choice is unaffected.
module max2_cell
  import map_dec_pkg::*;
#(
  parameter int N      = 12,
  parameter int IW     = 2,
  parameter int SIGNED = 0
) (
  input  logic [N-1:0]  a,
  input  logic [IW-1:0] ia,
  input  logic [N-1:0]  b,
  input  logic [IW-1:0] ib,
  output logic [N-1:0]  y,
  output logic [IW-1:0] iy
);

  logic         b_gt;
  logic [N-1:0] sel;

  if (SIGNED != 0) begin : g_scmp
    assign b_gt = $signed(b) > $signed(a);
  end else begin : g_ucmp
    assign b_gt = b > a;
  end

  assign sel = b_gt ? b : a;
  assign iy  = b_gt ? ib : ia;

`ifdef MAX_TREE_CORR_EN
  logic [N-1:0] oth;
  logic [N:0]   sel_x;
  logic [N:0]   oth_x;
  logic [N:0]   d;
  logic [1:0]   corr;

  assign oth = b_gt ? a : b;

  if (SIGNED != 0) begin : g_sext
    assign sel_x = {sel[N-1], sel};
    assign oth_x = {oth[N-1], oth};
  end else begin : g_zext
    assign sel_x = {1'b0, sel};
    assign oth_x = {1'b0, oth};
  end

  // sel >= oth, so the N+1-bit difference is the non-negative distance
  assign d = sel_x - oth_x;

  // correction lookup on the metric distance
  always_comb begin
    corr = 2'd0;
    if (d == (N+1)'(CORR_T0))       corr = 2'(CORR_V0);
    else if (d <= (N+1)'(CORR_T1))  corr = 2'(CORR_V1);
    else if (d <= (N+1)'(CORR_T2))  corr = 2'(CORR_V2);
  end

  assign y = N'(sat_add(34'($signed(sel_x)), corr, N, SIGNED != 0));
`else
  assign y = sel;
`endif

endmodule

// File: rtl/max_tree_pipe.sv
// max_tree_pipe: pipelined M-input max/argmax tree with valid/ready flow.
// Nodes are numbered heap-style: node 1 is the root (final stage), node n
// reduces children 2n and 2n+1; children numbered >= M are the inputs
// in_data[(c-M)*N +: N]. Every node output is registered, giving log2(M)
// stages. One global enable advances or freezes the whole pipe.
// Optional feature macro: MAX_TREE_CORR_EN (max* correction in max2_cell).
module max_tree_pipe
  import map_dec_pkg::*;
#(
  parameter  int N      = 12,
  parameter  int M      = 4,
  parameter  int SIGNED = 0,
  localparam int IW     = iw_of(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M*N-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   out_max,
  output logic [IW-1:0]  out_idx,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int L = $clog2(M);

  logic          adv;
  logic [L:1]    vld;
  logic [N-1:0]  node_dat [M];
  logic [IW-1:0] node_idx [M];
  logic [N-1:0]  cell_dat [M];
  logic [IW-1:0] cell_idx [M];

  assign adv       = !vld[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[L];
  assign out_max   = node_dat[1];
  assign out_idx   = node_idx[1];

  // slot 0 is not a tree node; tie it off so the arrays stay uniform
  assign cell_dat[0] = '0;
  assign cell_idx[0] = '0;

  for (genvar n = 1; n < M; n++) begin : g_node
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [IW-1:0] ia;
    logic [IW-1:0] ib;

    if (2*n >= M) begin : g_leaf
      assign a  = in_data[(2*n-M)*N +: N];
      assign b  = in_data[(2*n+1-M)*N +: N];
      assign ia = IW'(2*n-M);
      assign ib = IW'(2*n+1-M);
    end else begin : g_inner
      assign a  = node_dat[2*n];
      assign b  = node_dat[2*n+1];
      assign ia = node_idx[2*n];
      assign ib = node_idx[2*n+1];
    end

    max2_cell #(
      .N      (N),
      .IW     (IW),
      .SIGNED (SIGNED)
    ) u_cell (
      .a  (a),
      .ia (ia),
      .b  (b),
      .ib (ib),
      .y  (cell_dat[n]),
      .iy (cell_idx[n])
    );
  end

  // advance all stages together when the output slot is free or draining
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int n = 0; n < M; n++) begin
        node_dat[n] <= '0;
        node_idx[n] <= '0;
      end
    end else if (adv) begin
      vld[1] <= in_valid;
      for (int k = 2; k <= L; k++) begin
        vld[k] <= vld[k-1];
      end
      for (int n = 0; n < M; n++) begin
        node_dat[n] <= cell_dat[n];
        node_idx[n] <= cell_idx[n];
      end
    end
  end

endmodule

// File: tb/tb_max_tree_pipe.sv
// tb_max_tree_pipe: directed bench for max_tree_pipe (N=12, M=4), with an
// unsigned and a signed instance sharing the same stimulus.
module tb_max_tree_pipe;

  localparam int N  = 12;
  localparam int M  = 4;
  localparam int IW = 2;

`ifdef MAX_TREE_CORR_EN
  localparam int RST_EXP = 502;
`else
  localparam int RST_EXP = 500;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [M*N-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;

  logic           in_ready, out_valid;
  logic [N-1:0]   out_max;
  logic [IW-1:0]  out_idx;
  logic           in_ready_s, out_valid_s;
  logic [N-1:0]   out_max_s;
  logic [IW-1:0]  out_idx_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  max_tree_pipe #(.N(N), .M(M), .SIGNED(0)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  max_tree_pipe #(.N(N), .M(M), .SIGNED(1)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .out_max   (out_max_s),
    .out_idx   (out_idx_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M*N-1:0] pack4(input logic [N-1:0] v0, input logic [N-1:0] v1,
                                           input logic [N-1:0] v2, input logic [N-1:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // stream vector k: element k%4 carries 200+k, the others carry their index
  function automatic logic [M*N-1:0] bp_vec(input int k);
    logic [M*N-1:0] v;
    for (int j = 0; j < M; j++) begin
      v[j*N +: N] = (j == k % M) ? N'(200 + k) : N'(j);
    end
    return v;
  endfunction

  // one isolated vector: accept, check latency, result, then drain
  task automatic send_one(input string tag, input logic [M*N-1:0] v,
                          input int em, input int ei,
                          input int ems, input int eis, input bit chk_s);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".max"}, 32'(out_max), 32'(em));
    chk({tag, ".idx"}, 32'(out_idx), 32'(ei));
    if (chk_s) begin
      chk({tag, ".s_valid"}, 32'(out_valid_s), 32'd1);
      chk({tag, ".s_max"}, 32'(out_max_s), 32'(ems));
      chk({tag, ".s_idx"}, 32'(out_idx_s), 32'(eis));
    end
    @(posedge clk); #1;
    chk({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int  sent;
    int  got;
    bit  acc;

    // reset held with a valid vector presented
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = pack4(12'd10, 12'd500, 12'd3, 12'd499);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.max", 32'(out_max), 32'd0);
    chk("rst.idx", 32'(out_idx), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst.lat", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst.first_valid", 32'(out_valid), 32'd1);
    chk("rst.first_max", 32'(out_max), 32'(RST_EXP));
    chk("rst.first_idx", 32'(out_idx), 32'd1);
    @(posedge clk); #1;

`ifdef MAX_TREE_CORR_EN
    send_one("corr.eq",  pack4(12'd100, 12'd100, 12'd0, 12'd0), 103, 0, 0, 0, 1'b0);
    send_one("corr.d4",  pack4(12'd100, 12'd104, 12'd0, 12'd0), 105, 1, 0, 0, 1'b0);
    send_one("corr.sat", pack4(12'd4095, 12'd4095, 12'd0, 12'd0), 4095, 0, 0, 0, 1'b0);
`else
    send_one("basic", pack4(12'd10, 12'd500, 12'd3, 12'd499), 500, 1, 500, 1, 1'b1);
    send_one("tie_all", pack4(12'd7, 12'd7, 12'd7, 12'd7), 7, 0, 7, 0, 1'b1);
    send_one("tie_mid", pack4(12'd1, 12'd9, 12'd9, 12'd2), 9, 1, 9, 1, 1'b1);
    send_one("neg", pack4(12'hFFB, 12'hFFF, 12'h800, 12'hFFD), 'hFFF, 1, 'hFFF, 1, 1'b1);
    send_one("msb", pack4(12'h800, 12'h7FF, 12'h000, 12'h001), 'h800, 0, 'h7FF, 1, 1'b1);
    send_one("plain.eq",  pack4(12'd100, 12'd100, 12'd0, 12'd0), 100, 0, 100, 0, 1'b1);
    send_one("plain.d4",  pack4(12'd100, 12'd104, 12'd0, 12'd0), 104, 1, 104, 1, 1'b1);
    send_one("plain.top", pack4(12'd4095, 12'd4095, 12'd0, 12'd0), 4095, 0, 0, 2, 1'b1);
`endif

    // six back-to-back vectors with out_ready low in cycles 4..6
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 6);
      in_data   = bp_vec(sent);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        chk("bp.stall_ready", 32'(in_ready), 32'd0);
        chk("bp.stall_ready_s", 32'(in_ready_s), 32'd0);
      end
      if (out_valid) begin
        if (got < 6) begin
          chk("bp.max", 32'(out_max), 32'(200 + got));
          chk("bp.idx", 32'(out_idx), 32'(got % M));
        end else begin
          chk("bp.extra", 32'(out_valid), 32'd0);
        end
        if (out_ready) got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.sent", 32'(sent), 32'd6);
    chk("bp.delivered", 32'(got), 32'd6);

    // reset with two vectors in flight
    in_valid = 1'b1;
    in_data  = pack4(12'd1, 12'd2, 12'd3, 12'd900);
    @(posedge clk); #1;
    in_data  = pack4(12'd800, 12'd1, 12'd2, 12'd3);
    @(posedge clk); #1;
    chk("rstmid.pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid.valid", 32'(out_valid), 32'd0);
    chk("rstmid.max", 32'(out_max), 32'd0);
    chk("rstmid.idx", 32'(out_idx), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstmid.quiet", 32'(out_valid), 32'd0);
    end
    send_one("rstmid.recover", pack4(12'd5, 12'd600, 12'd7, 12'd1000), 1000, 3, 1000, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/max_tree_pipe.md
Name: max_tree_pipe

Overview:
- Pipelined M-input max/argmax reduction for max-log-MAP metric selection in the decoder datapath.
- Generalises the 2-input max comparator: parametrised width, input count and signedness.
- Registered binary tree with valid/ready flow control, plus argmax index output.
- Sits between the branch/state-metric adders and the metric normalisation/LLR stages.

Parameters:
- N, 12, metric width in bits.
- M, 4, number of inputs; power of two, 2..16.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- IW, $clog2(M), index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  M*N  packed metrics; element i is in_data[i*N +: N].
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts a vector this cycle.
- out_max  out  N  maximum of the accepted vector.
- out_idx  out  IW  index of the winning element.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0 at a clk edge, all stage valids clear, and out_max, out_idx and all pipeline data/index registers go to 0. Reset mid-operation discards every in-flight vector; there is no flush handshake.
- Pipeline structure: L = log2(M) registered stages.
  - Stage k reduces pairs from stage k-1.
  - Stage 1 operates on in_data.
  - Each stage holds data, index and a valid bit.
- Pairwise rule for (a, ia) vs (b, ib), with a from the lower index:
  - If a > b, select a.
  - If b > a, select b.
  - If a == b, select a.
  - Lower index wins ties.
  - Comparison is signed when SIGNED=1.
- Latency: a vector accepted at edge t appears on out_valid/out_max/out_idx after edge t+L-1, i.e. L cycles after acceptance, provided there are no stalls.
- Flow control, with one global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - When adv=1, all stages shift forward by one, and stage 1 loads in_valid.
  - When adv=0, all stage registers hold.
- Handshake rules:
  - A transfer occurs on in_valid && in_ready, or on out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_max and out_idx are stable.
- Bubbles: an in_valid=0 cycle with adv=1 inserts an empty slot. Empty slots propagate without raising out_valid.
- Throughput: one vector per cycle when out_ready stays 1.
- Width: no growth; output width equals N.
- Single-cycle out_ready=0 with a full pipe: no data loss and no duplication.

Optional Feature:
- Macro: MAX_TREE_CORR_EN. Selects Jacobian-log max* instead of plain max at each pairwise cell.
- Defined: result = sel + corr(|a-b|), where d=|a-b| is computed at N+1 bits.
  - corr = 3 for d=0.
  - corr = 2 for d in 1..2.
  - corr = 1 for d in 3..5.
  - corr = 0 for d >= 6.
  - The sum saturates at the type maximum: 2^N-1 unsigned, 2^(N-1)-1 signed.
  - Index selection is unchanged.
- Undefined: plain max. No correction logic and no extra ports. Latency is identical in both builds.

Decomposition:
- Package map_dec_pkg holds:
  - correction LUT thresholds/values (CORR_T0=0, CORR_T1=2, CORR_T2=5, values 3/2/1);
  - function sat_add;
  - function clog2-based IW helper.
- Sub-module max2_cell: combinational pairwise compare, select, index and optional correction. It is instantiated M-1 times in a generate tree; pipeline registers live in max_tree_pipe.

Test Plan (N=12, M=4, SIGNED=0 unless stated):
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_max=0, out_idx=0; the first output appears 2 cycles after release and acceptance.
- Basic: vector {10, 500, 3, 499} accepted at t -> out_max=500, out_idx=1, out_valid at t+2.
- Ties: {7, 7, 7, 7} -> out_idx=0. Also {1, 9, 9, 2} -> out_idx=1.
- Signed build: SIGNED=1 with {-5, -1, -2048, -3} -> out_max=-1 (0xFFF), out_idx=1. Same vector with SIGNED=0 -> out_max=0xFFF, out_idx=1; also check {0x800, 0x7FF, 0, 1} -> idx 0 unsigned, idx 1 signed.
- Backpressure: stream 6 back-to-back vectors and drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 6 results delivered in order with no duplication. Reset asserted mid-stream -> no further out_valid until new input.
- MAX_TREE_CORR_EN build:
  - {100, 100, 0, 0} -> out_max=103 (final stage d=100 adds 0).
  - {100, 104, 0, 0} -> 105.
  - {4095, 4095, 0, 0} -> saturates at 4095.
